// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader
//   Feeds configuration bytes from a valid/ready stream into the fabric shift
//   chain (prog_en/prog_in), LSB first, for exactly CHAIN_LEN bits per pass.
//   An optional verify pass compares the chain readback (prog_out) against a
//   resent copy of the bitstream and latches a sticky error on mismatch.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, verify   start pulse (accepted in IDLE); verify sampled with start
//   s_data/s_valid/s_ready  byte stream in
//   prog_en/prog_in chain shift enable and serial data (registered)
//   prog_out        serial readback from chain end
//   busy, done, error, bit_count  host-side status
module cfg_bitstream_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             verify,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             prog_en,
    output logic             prog_in,
    input  logic             prog_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        FINISH
    } state_t;

    state_t             state_q, state_n;
    logic [7:0]         byte_q, byte_n;
    logic [2:0]         idx_q, idx_n;
    logic               full_q, full_n;
    logic               verify_q, verify_n;
    logic               error_q, error_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               prog_en_q, prog_en_n;
    logic               prog_in_q, prog_in_n;

    logic               active;
    logic               shift;
    logic               last;
    logic               drain;
    logic               take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            idx_q     <= '0;
            full_q    <= 1'b0;
            verify_q  <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
            prog_en_q <= 1'b0;
            prog_in_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            byte_q    <= byte_n;
            idx_q     <= idx_n;
            full_q    <= full_n;
            verify_q  <= verify_n;
            error_q   <= error_n;
            cnt_q     <= cnt_n;
            prog_en_q <= prog_en_n;
            prog_in_q <= prog_in_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        byte_n   = byte_q;
        idx_n    = idx_q;
        full_n   = full_q;
        verify_n = verify_q;
        error_n  = error_q;
        cnt_n    = cnt_q;

        active = (state_q == LOAD) || (state_q == VERIFY);
        // A full buffer is the bit currently on prog_en/prog_in.
        shift  = full_q;
        last   = shift && (cnt_q == CNT_W'(CHAIN_LEN - 1));
        drain  = shift && (idx_q == 3'd7);
        // Ready on the bit-7 cycle allows gap-free refill, but never on the
        // final bit of a pass (leftover bits are discarded there).
        s_ready = active && (!full_q || drain) && !last;
        take    = s_valid && s_ready;

        if (shift) begin
            idx_n = idx_q + 3'd1;
            if (cnt_q != CNT_W'(CHAIN_LEN))
                cnt_n = cnt_q + CNT_W'(1);
            if (drain || last)
                full_n = 1'b0;
            if ((state_q == VERIFY) && (prog_out != prog_in_q))
                error_n = 1'b1;
        end

        if (take) begin
            byte_n = s_data;
            idx_n  = '0;
            full_n = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_n  = LOAD;
                    verify_n = verify;
                    error_n  = 1'b0;
                    cnt_n    = '0;
                end
            end
            LOAD: begin
                if (last) begin
                    if (verify_q) begin
                        state_n = VERIFY;
                        cnt_n   = '0;
                    end else begin
                        state_n = FINISH;
                    end
                end
            end
            VERIFY: begin
                if (last)
                    state_n = FINISH;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs registered from the next buffer state so they are valid
        // for exactly the cycle in which the buffer holds that bit.
        prog_en_n = full_n;
        prog_in_n = full_n ? byte_n[idx_n] : 1'b0;
    end

    assign prog_en   = prog_en_q;
    assign prog_in   = prog_in_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign error     = error_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
module tb_cfg_bitstream_loader;

    localparam int CL = 20;
    localparam int CW = $clog2(CL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          verify;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          prog_en;
    logic          prog_in;
    logic          prog_out;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] bit_count;

    always #5 clk = ~clk;

    cfg_bitstream_loader #(
        .CHAIN_LEN(CL),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .verify   (verify),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .prog_en  (prog_en),
        .prog_in  (prog_in),
        .prog_out (prog_out),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .bit_count(bit_count)
    );

    int errors = 0;
    int checks = 0;

    bit exp_q[$];
    int en_count   = 0;
    int runs       = 0;
    int done_count = 0;
    logic en_prev  = 1'b0;

    // Fabric chain model: shifts on prog_en, end of chain drives prog_out.
    logic [CL-1:0] chain = '0;
    int            sh_count = 0;
    int            sh_base  = 0;
    logic          corrupt  = 1'b0;

    assign prog_out = chain[CL-1] ^ (corrupt && ((sh_count - sh_base) == CL + 7));

    always @(posedge clk) begin
        if (prog_en === 1'b1) begin
            chain    <= {chain[CL-2:0], prog_in};
            sh_count <= sh_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every shifted bit is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (prog_en === 1'b1) begin
                en_count++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_prog_en", 32'(prog_en), 32'd0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("sb_prog_in", 32'(prog_in), 32'(e));
                end
            end
            if ((prog_en === 1'b1) && !en_prev)
                runs++;
            en_prev = (prog_en === 1'b1);
            if (done === 1'b1)
                done_count++;
        end
    end

    task automatic push_byte(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(b[i]);
    endtask

    task automatic push_stream();
        push_byte(8'hA5, 8);
        push_byte(8'h3C, 8);
        push_byte(8'hFF, 4);
    endtask

    task automatic do_start(input logic v);
        @(posedge clk); #1;
        start  = 1'b1;
        verify = v;
        @(posedge clk); #1;
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        logic got;
        got     = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk); #1;
            if (got) break;
        end
        if (!got)
            check("send_handshake_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_checks(input int en0, input int r0, input int d0,
                                 input int exp_en, input int exp_runs, input logic exp_err);
        check("fin_bit_count", 32'(bit_count), CL);
        check("fin_busy", 32'(busy), 32'd1);
        check("fin_error", 32'(error), 32'(exp_err));
        check("fin_en_cycles", en_count - en0, exp_en);
        check("fin_en_runs", runs - r0, exp_runs);
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_bit_count_held", 32'(bit_count), CL);
        check("idle_error_held", 32'(error), 32'(exp_err));
        check("done_pulses", done_count - d0, 32'd1);
        check("sb_leftover", exp_q.size(), 32'd0);
    endtask

    task automatic plain_load();
        int en0, r0, d0;
        en0 = en_count; r0 = runs; d0 = done_count;
        push_stream();
        do_start(1'b0);
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        wait_done();
        finish_checks(en0, r0, d0, 20, 1, 1'b0);
    endtask

    initial begin
        int en0, r0, d0;
        logic hit;

        rst = 1'b1; start = 1'b0; verify = 1'b0; s_data = '0; s_valid = 1'b0;
        #1;
        check("rst_prog_en", 32'(prog_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Plain load, back-to-back bytes.
        plain_load();

        // Load + verify with correct readback.
        en0 = en_count; r0 = runs; d0 = done_count;
        sh_base = sh_count;
        push_stream(); push_stream();
        do_start(1'b1);
        send(8'hA5); send(8'h3C); send(8'hFF);
        send(8'hA5); send(8'h3C); send(8'hFF);
        wait_done();
        finish_checks(en0, r0, d0, 40, 2, 1'b0);

        // Verify with corrupted readback at verify bit 7.
        en0 = en_count; r0 = runs; d0 = done_count;
        sh_base = sh_count;
        corrupt = 1'b1;
        push_stream(); push_stream();
        do_start(1'b1);
        send(8'hA5); send(8'h3C); send(8'hFF);
        send(8'hA5); send(8'h3C); send(8'hFF);
        wait_done();
        finish_checks(en0, r0, d0, 40, 2, 1'b1);
        corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("error_sticky_idle", 32'(error), 32'd1);

        // Starved stream; the start also clears the sticky error.
        en0 = en_count; r0 = runs; d0 = done_count;
        push_stream();
        do_start(1'b0);
        check("start_clears_error", 32'(error), 32'd0);
        send(8'hA5);
        repeat (13) @(posedge clk);
        #1;
        send(8'h3C);
        repeat (13) @(posedge clk);
        #1;
        send(8'hFF);
        wait_done();
        finish_checks(en0, r0, d0, 20, 3, 1'b0);

        // Asynchronous reset mid-load at bit 9.
        en0 = en_count;
        push_stream();
        do_start(1'b0);
        send(8'hA5);
        s_data  = 8'h3C;
        s_valid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bit_count == CW'(9)) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_reach_bit9", 32'(hit), 32'd1);
        check("pre_rst_prog_en", 32'(prog_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_prog_en", 32'(prog_en), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_s_ready", 32'(s_ready), 32'd0);
        check("async_bit_count", 32'(bit_count), 32'd0);
        s_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_bits_before_abort", en_count - en0, 32'd9);
        plain_load();

        // s_valid while idle: no handshake, no shifting.
        en0 = en_count;
        s_data  = 8'h5A;
        s_valid = 1'b1;
        hit = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (s_ready !== 1'b0) hit = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("idle_no_ready", 32'(hit), 32'd0);
        check("idle_no_shift", en_count - en0, 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);

        // start pulsed mid-load must not restart the pass.
        en0 = en_count; r0 = runs; d0 = done_count;
        push_stream();
        do_start(1'b0);
        send(8'hA5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(8'h3C);
        send(8'hFF);
        wait_done();
        finish_checks(en0, r0, d0, 20, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
